// File: rtl/prog_run_pkg.sv
// prog_run_pkg: shared types and default constants for the run-sequencing
// controller and its cycle counter.
//   run_state_e   : controller state encoding
//   DEF_CYC_W     : default cycle counter width
//   DEF_TIMEOUT   : default watchdog limit in cycles
//   DEF_RESET_CYC : default number of cycles the core is held in reset
package prog_run_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RST   = 3'd1,
        START = 3'd2,
        RUN   = 3'd3,
        DONE  = 3'd4
    } run_state_e;

    localparam int          DEF_CYC_W     = 16;
    localparam int unsigned DEF_TIMEOUT   = 4000;
    localparam int          DEF_RESET_CYC = 2;

endpackage

// File: rtl/run_cycle_ctr.sv
// run_cycle_ctr: CYC_W-bit saturating up-counter with synchronous clear and
// count enable, plus a flag that is high while the count equals TIMEOUT.
// Ports:
//   clk      : clock, posedge
//   rst      : synchronous active-high reset (count -> 0)
//   clr      : clear count to 0 (priority over en)
//   en       : increment by one, saturating at all-ones
//   count    : current count
//   at_limit : count == TIMEOUT
module run_cycle_ctr
    import prog_run_pkg::*;
#(
    parameter int          CYC_W   = DEF_CYC_W,
    parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    output logic [CYC_W-1:0] count,
    output logic             at_limit
);

    localparam logic [CYC_W-1:0] LIMIT = CYC_W'(TIMEOUT);

    logic [CYC_W-1:0] count_q;
    logic [CYC_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en && (count_q != '1)) begin
            count_d = count_q + CYC_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count    = count_q;
    assign at_limit = (count_q == LIMIT);

endmodule

// File: rtl/prog_run_ctrl.sv
// prog_run_ctrl: run-sequencing controller in front of the processor top.
// On an accepted Go it latches the program index, holds the core in reset for
// RESET_CYC cycles, pulses Start for one cycle, then counts cycles until the
// core acknowledges or the watchdog expires, and finally pulses Done.
// Optional build macro: RUN_ABORT_EN adds the Abort input.
// Ports:
//   Clk, Reset : clock (posedge) and synchronous active-high reset
//   Go         : run request, only accepted in IDLE
//   ProgSel    : program index, latched with an accepted Go
//   CoreAck    : completion acknowledge from the core
//   Abort      : (RUN_ABORT_EN only) cancel the current run
//   CoreReset  : reset to the core
//   CoreStart  : one-cycle start pulse to the core
//   ProgIdx    : latched program index
//   Busy       : high in RST/START/RUN
//   Done       : one-cycle completion pulse
//   TimedOut   : last run ended by watchdog (sticky until next accepted Go)
//   CycleCt    : cycle count of the last/current run
module prog_run_ctrl
    import prog_run_pkg::*;
#(
    parameter int          NUM_PROGS = 3,
    parameter int          CYC_W     = DEF_CYC_W,
    parameter int unsigned TIMEOUT   = DEF_TIMEOUT,
    parameter int          RESET_CYC = DEF_RESET_CYC
) (
    input  logic                         Clk,
    input  logic                         Reset,
    input  logic                         Go,
    input  logic [$clog2(NUM_PROGS)-1:0] ProgSel,
    input  logic                         CoreAck,
`ifdef RUN_ABORT_EN
    input  logic                         Abort,
`endif
    output logic                         CoreReset,
    output logic                         CoreStart,
    output logic [$clog2(NUM_PROGS)-1:0] ProgIdx,
    output logic                         Busy,
    output logic                         Done,
    output logic                         TimedOut,
    output logic [CYC_W-1:0]             CycleCt
);

    localparam int SEL_W  = $clog2(NUM_PROGS);
    localparam int RCNT_W = (RESET_CYC > 1) ? $clog2(RESET_CYC) : 1;
    localparam logic [RCNT_W-1:0] RCNT_LOAD = RCNT_W'(RESET_CYC - 1);

    run_state_e        state_q,      state_d;
    logic [RCNT_W-1:0] rst_cnt_q,    rst_cnt_d;
    logic [SEL_W-1:0]  prog_idx_q,   prog_idx_d;
    logic              timed_out_q,  timed_out_d;
    logic              core_reset_q, core_reset_d;
    logic              core_start_q, core_start_d;
    logic              busy_q,       busy_d;
    logic              done_q,       done_d;
`ifdef RUN_ABORT_EN
    // Marks the single forced-reset cycle of an abort so RST exits to IDLE.
    logic              abort_q,      abort_d;
`endif

    logic             ctr_clr;
    logic             ctr_en;
    logic             ctr_at_limit;
    logic [CYC_W-1:0] cycle_ct;

    run_cycle_ctr #(
        .CYC_W   (CYC_W),
        .TIMEOUT (TIMEOUT)
    ) u_cycle_ctr (
        .clk      (Clk),
        .rst      (Reset),
        .clr      (ctr_clr),
        .en       (ctr_en),
        .count    (cycle_ct),
        .at_limit (ctr_at_limit)
    );

    always_comb begin
        state_d     = state_q;
        rst_cnt_d   = rst_cnt_q;
        prog_idx_d  = prog_idx_q;
        timed_out_d = timed_out_q;
        ctr_clr     = 1'b0;
        ctr_en      = 1'b0;
`ifdef RUN_ABORT_EN
        abort_d     = abort_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (Go) begin
                    state_d     = RST;
                    rst_cnt_d   = RCNT_LOAD;
                    prog_idx_d  = ProgSel;
                    timed_out_d = 1'b0;
                    ctr_clr     = 1'b1;
                end
            end
            RST: begin
                if (rst_cnt_q == '0) begin
                    state_d = START;
`ifdef RUN_ABORT_EN
                    if (abort_q) begin
                        state_d = IDLE;
                    end
                    abort_d = 1'b0;
`endif
                end else begin
                    rst_cnt_d = rst_cnt_q - RCNT_W'(1);
                end
            end
            START: begin
                state_d = RUN;
                ctr_en  = 1'b1;
            end
            RUN: begin
                // Ack takes priority over the watchdog in the same cycle.
                if (CoreAck) begin
                    state_d = DONE;
                end else if (ctr_at_limit) begin
                    state_d     = DONE;
                    timed_out_d = 1'b1;
                end else begin
                    ctr_en = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
`ifdef RUN_ABORT_EN
        // Abort reuses RST for exactly one cycle and freezes the count.
        if (Abort && !abort_q &&
            ((state_q == RST) || (state_q == START) || (state_q == RUN))) begin
            state_d     = RST;
            rst_cnt_d   = '0;
            abort_d     = 1'b1;
            timed_out_d = 1'b0;
            ctr_en      = 1'b0;
        end
`endif
    end

    // Outputs are decoded from the next state and registered, so each output
    // reflects the state the controller is in during that cycle.
    always_comb begin
        core_reset_d = (state_d == RST);
        core_start_d = (state_d == START);
        busy_d       = (state_d == RST) || (state_d == START) || (state_d == RUN);
        done_d       = (state_d == DONE);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q      <= IDLE;
            rst_cnt_q    <= '0;
            prog_idx_q   <= '0;
            timed_out_q  <= 1'b0;
            core_reset_q <= 1'b0;
            core_start_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
`ifdef RUN_ABORT_EN
            abort_q      <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            rst_cnt_q    <= rst_cnt_d;
            prog_idx_q   <= prog_idx_d;
            timed_out_q  <= timed_out_d;
            core_reset_q <= core_reset_d;
            core_start_q <= core_start_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
`ifdef RUN_ABORT_EN
            abort_q      <= abort_d;
`endif
        end
    end

    assign CoreReset = core_reset_q;
    assign CoreStart = core_start_q;
    assign ProgIdx   = prog_idx_q;
    assign Busy      = busy_q;
    assign Done      = done_q;
    assign TimedOut  = timed_out_q;
    assign CycleCt   = cycle_ct;

endmodule

// File: doc/prog_run_ctrl.md
Name: prog_run_ctrl

Overview:
Run-sequencing controller that sits directly upstream of the processor top level and drives its Start/Reset inputs.
- Accepts a host "go" request with a program index, then holds the core in reset for a fixed number of cycles.
- Pulses the core's Start, then counts cycles until the core raises Ack or a watchdog limit expires.
- Reports Done, the cycle count, and a timeout flag to the host or testbench.

Parameters:
NUM_PROGS, 3, number of selectable programs; ProgSel/ProgIdx width = $clog2(NUM_PROGS)
CYC_W, 16, width of cycle counter
TIMEOUT, 16'd4000, watchdog limit in cycles (must be < 2**CYC_W)
RESET_CYC, 2, cycles CoreReset is held high per run (>=1)

Ports:
Clk  input  1  clock, posedge
Reset  input  1  synchronous, active-high reset of this block
Go  input  1  host run request, sampled only in IDLE
ProgSel  input  $clog2(NUM_PROGS)  program to run, latched with Go
CoreAck  input  1  Ack from processor top level
CoreReset  output  1  reset to processor (integrator ORs with system Reset)
CoreStart  output  1  Start to processor
ProgIdx  output  $clog2(NUM_PROGS)  latched program index to core start-address select
Busy  output  1  high in RST/START/RUN
Done  output  1  one-cycle completion pulse
TimedOut  output  1  run ended by watchdog; sticky until next accepted Go
CycleCt  output  CYC_W  cycles of last/current run

Behaviour:
- Interface: one clock, Clk; reset is synchronous and active-high, port Reset.
- Reset values: state IDLE; all outputs 0, including CycleCt and ProgIdx. Reset mid-run aborts immediately with no Done.
- Outputs are Moore-decoded from registered state and counters; no combinational input-to-output paths.
- IDLE:
  - Go=1 moves to RST next cycle.
  - ProgIdx latches ProgSel.
  - CycleCt clears to 0 and TimedOut clears to 0.
  - Go=0 stays in IDLE.
- RST:
  - CoreReset=1 for exactly RESET_CYC cycles, counted by an internal down-counter, then START.
- START:
  - CoreStart=1 for exactly 1 cycle, then RUN.
  - CoreAck is ignored here.
- RUN:
  - Each cycle with CoreAck=0: if CycleCt==TIMEOUT, go to DONE with TimedOut<=1; otherwise keep counting.
  - CoreAck=1: go to DONE; CycleCt holds.
  - If CoreAck=1 and the timeout condition occur in the same cycle, Ack wins and TimedOut stays 0.
- DONE:
  - Done=1 for 1 cycle, then IDLE.
  - CycleCt, TimedOut and ProgIdx hold until the next accepted Go.
- Counting rule:
  - CycleCt increments in START and in every RUN cycle with CoreAck=0.
  - It saturates at all-ones and never wraps.
  - The final value equals cycles from CoreStart high through the last Ack-low RUN cycle.
- Latency: Go sampled at cycle t gives CoreReset high t+1..t+RESET_CYC, CoreStart at t+RESET_CYC+1, RUN from t+RESET_CYC+2.
- Go while Busy or in DONE is ignored (not queued). ProgSel changes outside IDLE have no effect.
- Busy=0 in IDLE and DONE.

Optional Feature:
RUN_ABORT_EN
- Defined:
  - Adds input Abort (1 bit).
  - Abort=1 in RST, START or RUN forces one cycle of CoreReset=1, then IDLE.
  - No Done pulse; TimedOut=0; CycleCt holds its value at abort.
  - Abort in IDLE or DONE is ignored.
- Undefined: no Abort port; runs end only via CoreAck, watchdog, or Reset.

Decomposition:
- Package prog_run_pkg: state enum {IDLE, RST, START, RUN, DONE}; default CYC_W, TIMEOUT and RESET_CYC constants.
- Sub-module run_cycle_ctr: CYC_W-bit saturating counter with clear, enable and TIMEOUT-compare output. Reused elsewhere for instruction counting.

Test Plan:
- Reset, then Go=1 with ProgSel=2, RESET_CYC=2; CoreAck rises on the 5th RUN cycle -> CoreReset high 2 cycles, CoreStart high 1 cycle, Done pulses once, CycleCt=5, ProgIdx=2, TimedOut=0.
- TIMEOUT=20 with CoreAck held 0 -> DONE entered after CycleCt reaches 20, TimedOut=1, Done pulses once, Busy drops.
- CoreAck=1 continuously from before Go -> ignored in RST/START; first RUN cycle sees Ack, CycleCt=1.
- Go pulsed again during RUN and again during DONE -> no restart; the next run begins only on Go sampled in IDLE. The previous CycleCt and TimedOut clear at that point.
- Reset asserted mid-RUN at CycleCt=7 -> next cycle all outputs 0, state IDLE, no Done.
- RUN_ABORT_EN defined, Abort in RUN at CycleCt=3 -> CoreReset=1 one cycle, then IDLE; Done stays 0, CycleCt=3.
